// File: rtl/axil_host_arbiter_if.sv
// AXI4-Lite bus bundle between the two-requester arbiter (master) and a
// single AXI4-Lite slave.
interface axil_host_arbiter_if;
    // write address channel
    logic [31:0] awaddr;
    logic        awvalid;
    logic        awready;
    // write data channel
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        wvalid;
    logic        wready;
    // write response channel
    logic [1:0]  bresp;
    logic        bvalid;
    logic        bready;
    // read address channel
    logic [31:0] araddr;
    logic        arvalid;
    logic        arready;
    // read data channel
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rvalid;
    logic        rready;

    modport master (
        output awaddr, awvalid, input awready,
        output wdata, wstrb, wvalid, input wready,
        input  bresp, bvalid, output bready,
        output araddr, arvalid, input arready,
        input  rdata, rresp, rvalid, output rready
    );

    modport slave (
        input  awaddr, awvalid, output awready,
        input  wdata, wstrb, wvalid, output wready,
        output bresp, bvalid, input bready,
        input  araddr, arvalid, output arready,
        output rdata, rresp, rvalid, input rready
    );
endinterface

// File: rtl/axil_host_arbiter.sv
// Two-requester round-robin arbiter in front of one AXI4-Lite master port.
// One transaction in flight at a time; ADDR+RESP is bounded by a timeout
// that forces an error completion. All outputs come straight from flops.
module axil_host_arbiter #(
    parameter int unsigned TIMEOUT_CYC = 1024
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        r0_req_i,
    input  logic        r0_we_i,
    input  logic [31:0] r0_addr_i,
    input  logic [31:0] r0_wdata_i,
    input  logic [3:0]  r0_wstrb_i,
    output logic        r0_ack_o,
    output logic [31:0] r0_rdata_o,
    output logic        r0_err_o,
    input  logic        r1_req_i,
    input  logic        r1_we_i,
    input  logic [31:0] r1_addr_i,
    input  logic [31:0] r1_wdata_i,
    input  logic [3:0]  r1_wstrb_i,
    output logic        r1_ack_o,
    output logic [31:0] r1_rdata_o,
    output logic        r1_err_o,
    output logic        owner_o,
    output logic        busy_o,
    axil_host_arbiter_if.master m_axi
);

    typedef enum logic [1:0] {ST_IDLE, ST_ADDR, ST_RESP, ST_DONE} state_t;

    localparam logic [15:0] TMO_LIMIT = 16'(TIMEOUT_CYC);

    // SLVERR (2'b10) and DECERR (2'b11) both report an error
    function automatic logic resp_is_err(input logic [1:0] resp);
        return (resp == 2'b10) || (resp == 2'b11);
    endfunction

    state_t      state_q, state_d;
    logic        owner_q, owner_d;
    logic        busy_q, busy_d;
    logic        we_q, we_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [3:0]  wstrb_q, wstrb_d;
    logic        awvalid_q, awvalid_d;
    logic        wvalid_q, wvalid_d;
    logic        arvalid_q, arvalid_d;
    logic        bready_q, bready_d;
    logic        rready_q, rready_d;
    logic        ack0_q, ack0_d;
    logic        ack1_q, ack1_d;
    logic [31:0] rdata0_q, rdata0_d;
    logic [31:0] rdata1_q, rdata1_d;
    logic        err0_q, err0_d;
    logic        err1_q, err1_d;
    logic [15:0] tmo_q, tmo_d;

    logic        grant_s;
    logic        grant_we_s;
    logic [15:0] tmo_inc_s;
    logic        fin_s;
    logic [31:0] fin_rdata_s;
    logic        fin_err_s;

    // State and output registers with synchronous reset
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            owner_q   <= 1'b1;
            busy_q    <= 1'b0;
            we_q      <= 1'b0;
            addr_q    <= 32'h0000_0000;
            wdata_q   <= 32'h0000_0000;
            wstrb_q   <= 4'h0;
            awvalid_q <= 1'b0;
            wvalid_q  <= 1'b0;
            arvalid_q <= 1'b0;
            bready_q  <= 1'b0;
            rready_q  <= 1'b0;
            ack0_q    <= 1'b0;
            ack1_q    <= 1'b0;
            rdata0_q  <= 32'h0000_0000;
            rdata1_q  <= 32'h0000_0000;
            err0_q    <= 1'b0;
            err1_q    <= 1'b0;
            tmo_q     <= 16'h0000;
        end else begin
            state_q   <= state_d;
            owner_q   <= owner_d;
            busy_q    <= busy_d;
            we_q      <= we_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            wstrb_q   <= wstrb_d;
            awvalid_q <= awvalid_d;
            wvalid_q  <= wvalid_d;
            arvalid_q <= arvalid_d;
            bready_q  <= bready_d;
            rready_q  <= rready_d;
            ack0_q    <= ack0_d;
            ack1_q    <= ack1_d;
            rdata0_q  <= rdata0_d;
            rdata1_q  <= rdata1_d;
            err0_q    <= err0_d;
            err1_q    <= err1_d;
            tmo_q     <= tmo_d;
        end
    end

    // Next-state logic: arbitration, AXI handshakes, timeout, completion
    always_comb begin
        state_d     = state_q;
        owner_d     = owner_q;
        we_d        = we_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        wstrb_d     = wstrb_q;
        awvalid_d   = awvalid_q;
        wvalid_d    = wvalid_q;
        arvalid_d   = arvalid_q;
        bready_d    = bready_q;
        rready_d    = rready_q;
        tmo_d       = tmo_q;
        ack0_d      = 1'b0;
        ack1_d      = 1'b0;
        rdata0_d    = 32'h0000_0000;
        rdata1_d    = 32'h0000_0000;
        err0_d      = 1'b0;
        err1_d      = 1'b0;
        grant_s     = 1'b0;
        grant_we_s  = 1'b0;
        fin_s       = 1'b0;
        fin_rdata_s = 32'h0000_0000;
        fin_err_s   = 1'b0;
        tmo_inc_s   = tmo_q + 16'd1;

        case (state_q)
            ST_IDLE: begin
                if (r0_req_i || r1_req_i) begin
                    // on a tie the requester that did not go last wins
                    if (r0_req_i && r1_req_i) begin
                        grant_s = ~owner_q;
                    end else begin
                        grant_s = r1_req_i;
                    end
                    if (grant_s) begin
                        grant_we_s = r1_we_i;
                        addr_d     = r1_addr_i;
                        wdata_d    = r1_wdata_i;
                        wstrb_d    = r1_wstrb_i;
                    end else begin
                        grant_we_s = r0_we_i;
                        addr_d     = r0_addr_i;
                        wdata_d    = r0_wdata_i;
                        wstrb_d    = r0_wstrb_i;
                    end
                    owner_d   = grant_s;
                    we_d      = grant_we_s;
                    awvalid_d = grant_we_s;
                    wvalid_d  = grant_we_s;
                    arvalid_d = ~grant_we_s;
                    tmo_d     = 16'h0000;
                    state_d   = ST_ADDR;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_ADDR: begin
                tmo_d = tmo_inc_s;
                if (tmo_inc_s == TMO_LIMIT) begin
                    awvalid_d = 1'b0;
                    wvalid_d  = 1'b0;
                    arvalid_d = 1'b0;
                    fin_s     = 1'b1;
                    fin_err_s = 1'b1;
                end else if (we_q) begin
                    // address and data channels retire independently
                    if (awvalid_q && m_axi.awready) begin
                        awvalid_d = 1'b0;
                    end else begin
                        awvalid_d = awvalid_q;
                    end
                    if (wvalid_q && m_axi.wready) begin
                        wvalid_d = 1'b0;
                    end else begin
                        wvalid_d = wvalid_q;
                    end
                    if ((!awvalid_q || m_axi.awready) && (!wvalid_q || m_axi.wready)) begin
                        bready_d = 1'b1;
                        state_d  = ST_RESP;
                    end else begin
                        state_d = ST_ADDR;
                    end
                end else begin
                    if (m_axi.arready) begin
                        arvalid_d = 1'b0;
                        rready_d  = 1'b1;
                        state_d   = ST_RESP;
                    end else begin
                        state_d = ST_ADDR;
                    end
                end
            end
            ST_RESP: begin
                tmo_d = tmo_inc_s;
                // a response arriving on the last allowed cycle still counts
                if (we_q && m_axi.bvalid) begin
                    bready_d  = 1'b0;
                    fin_s     = 1'b1;
                    fin_err_s = resp_is_err(m_axi.bresp);
                end else if (!we_q && m_axi.rvalid) begin
                    rready_d    = 1'b0;
                    fin_s       = 1'b1;
                    fin_rdata_s = m_axi.rdata;
                    fin_err_s   = resp_is_err(m_axi.rresp);
                end else if (tmo_inc_s == TMO_LIMIT) begin
                    bready_d  = 1'b0;
                    rready_d  = 1'b0;
                    fin_s     = 1'b1;
                    fin_err_s = 1'b1;
                end else begin
                    state_d = ST_RESP;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (fin_s) begin
            state_d = ST_DONE;
            if (owner_q) begin
                ack1_d   = 1'b1;
                rdata1_d = fin_rdata_s;
                err1_d   = fin_err_s;
            end else begin
                ack0_d   = 1'b1;
                rdata0_d = fin_rdata_s;
                err0_d   = fin_err_s;
            end
        end else begin
            ack0_d = 1'b0;
            ack1_d = 1'b0;
        end

        busy_d = (state_d != ST_IDLE);
    end

    assign r0_ack_o       = ack0_q;
    assign r0_rdata_o     = rdata0_q;
    assign r0_err_o       = err0_q;
    assign r1_ack_o       = ack1_q;
    assign r1_rdata_o     = rdata1_q;
    assign r1_err_o       = err1_q;
    assign owner_o        = owner_q;
    assign busy_o         = busy_q;
    assign m_axi.awaddr   = addr_q;
    assign m_axi.awvalid  = awvalid_q;
    assign m_axi.wdata    = wdata_q;
    assign m_axi.wstrb    = wstrb_q;
    assign m_axi.wvalid   = wvalid_q;
    assign m_axi.bready   = bready_q;
    assign m_axi.araddr   = addr_q;
    assign m_axi.arvalid  = arvalid_q;
    assign m_axi.rready   = rready_q;

endmodule

// File: tb/tb_axil_host_arbiter.sv
// Directed self-checking bench for axil_host_arbiter (TIMEOUT_CYC = 8).
module tb_axil_host_arbiter;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        r0_req, r0_we, r0_ack, r0_err;
    logic [31:0] r0_addr, r0_wdata, r0_rdata;
    logic [3:0]  r0_wstrb;
    logic        r1_req, r1_we, r1_ack, r1_err;
    logic [31:0] r1_addr, r1_wdata, r1_rdata;
    logic [3:0]  r1_wstrb;
    logic        owner, busy;
    int          checks = 0;
    int          errors = 0;

    axil_host_arbiter_if m_axi_if ();

    axil_host_arbiter #(.TIMEOUT_CYC(8)) dut (
        .clk(clk), .reset(reset),
        .r0_req_i(r0_req), .r0_we_i(r0_we), .r0_addr_i(r0_addr),
        .r0_wdata_i(r0_wdata), .r0_wstrb_i(r0_wstrb),
        .r0_ack_o(r0_ack), .r0_rdata_o(r0_rdata), .r0_err_o(r0_err),
        .r1_req_i(r1_req), .r1_we_i(r1_we), .r1_addr_i(r1_addr),
        .r1_wdata_i(r1_wdata), .r1_wstrb_i(r1_wstrb),
        .r1_ack_o(r1_ack), .r1_rdata_o(r1_rdata), .r1_err_o(r1_err),
        .owner_o(owner), .busy_o(busy),
        .m_axi(m_axi_if.master)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // requesters idle, slave zero-wait with OKAY responses
    task automatic idle_inputs();
        r0_req = 1'b0; r0_we = 1'b0; r0_addr = 32'h0; r0_wdata = 32'h0; r0_wstrb = 4'h0;
        r1_req = 1'b0; r1_we = 1'b0; r1_addr = 32'h0; r1_wdata = 32'h0; r1_wstrb = 4'h0;
        m_axi_if.awready = 1'b1; m_axi_if.wready = 1'b1; m_axi_if.arready = 1'b1;
        m_axi_if.bvalid = 1'b1; m_axi_if.bresp = 2'b00;
        m_axi_if.rvalid = 1'b1; m_axi_if.rresp = 2'b00; m_axi_if.rdata = 32'h0;
    endtask

    task automatic test_reset();
        idle_inputs();
        reset = 1'b1;
        tick(); tick();
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
        checks++; if (owner !== 1'b1) begin errors++; $display("FAIL reset_owner: got %b expected 1", owner); end
        checks++; if ({r0_ack, r1_ack, r0_err, r1_err} !== 4'b0000) begin errors++; $display("FAIL reset_ack_err: got %b expected 0000", {r0_ack, r1_ack, r0_err, r1_err}); end
        checks++; if ({r0_rdata, r1_rdata} !== 64'h0) begin errors++; $display("FAIL reset_rdata: got %h expected 0", {r0_rdata, r1_rdata}); end
        checks++; if ({m_axi_if.awvalid, m_axi_if.wvalid, m_axi_if.arvalid, m_axi_if.bready, m_axi_if.rready} !== 5'b00000) begin errors++; $display("FAIL reset_valids: got %b expected 00000", {m_axi_if.awvalid, m_axi_if.wvalid, m_axi_if.arvalid, m_axi_if.bready, m_axi_if.rready}); end
        checks++; if ({m_axi_if.awaddr, m_axi_if.wdata, m_axi_if.wstrb} !== 68'h0) begin errors++; $display("FAIL reset_addr_data: got %h expected 0", {m_axi_if.awaddr, m_axi_if.wdata, m_axi_if.wstrb}); end
        reset = 1'b0;
        tick();
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL idle_no_req_busy: got %b expected 0", busy); end
    endtask

    task automatic test_write_zero_wait();
        r0_we = 1'b1; r0_addr = 32'h8000_6008; r0_wdata = 32'h0000_005A; r0_wstrb = 4'h1; r0_req = 1'b1;
        tick(); // T+1
        checks++; if ({m_axi_if.awvalid, m_axi_if.wvalid, m_axi_if.arvalid} !== 3'b110) begin errors++; $display("FAIL wr_addr_valids: got %b expected 110", {m_axi_if.awvalid, m_axi_if.wvalid, m_axi_if.arvalid}); end
        checks++; if (m_axi_if.awaddr !== 32'h8000_6008) begin errors++; $display("FAIL wr_awaddr: got %h expected 80006008", m_axi_if.awaddr); end
        checks++; if (m_axi_if.wdata !== 32'h0000_005A) begin errors++; $display("FAIL wr_wdata: got %h expected 0000005a", m_axi_if.wdata); end
        checks++; if (m_axi_if.wstrb !== 4'h1) begin errors++; $display("FAIL wr_wstrb: got %h expected 1", m_axi_if.wstrb); end
        checks++; if ({busy, owner} !== 2'b10) begin errors++; $display("FAIL wr_busy_owner: got %b expected 10", {busy, owner}); end
        tick(); // T+2
        checks++; if ({m_axi_if.awvalid, m_axi_if.wvalid, m_axi_if.bready, r0_ack} !== 4'b0010) begin errors++; $display("FAIL wr_resp_phase: got %b expected 0010", {m_axi_if.awvalid, m_axi_if.wvalid, m_axi_if.bready, r0_ack}); end
        tick(); // T+3
        checks++; if ({r0_ack, r0_err, r1_ack, m_axi_if.bready} !== 4'b1000) begin errors++; $display("FAIL wr_ack_t3: got %b expected 1000", {r0_ack, r0_err, r1_ack, m_axi_if.bready}); end
        checks++; if (r0_rdata !== 32'h0) begin errors++; $display("FAIL wr_ack_rdata: got %h expected 0", r0_rdata); end
        r0_req = 1'b0;
        tick();
        checks++; if ({r0_ack, busy} !== 2'b00) begin errors++; $display("FAIL wr_after_ack: got %b expected 00", {r0_ack, busy}); end
        checks++; if (m_axi_if.awaddr !== 32'h8000_6008) begin errors++; $display("FAIL wr_addr_hold: got %h expected 80006008", m_axi_if.awaddr); end
    endtask

    task automatic test_round_robin();
        idle_inputs();
        reset = 1'b1; tick(); reset = 1'b0;
        m_axi_if.rdata = 32'hCAFE_0001;
        r0_addr = 32'h0000_0100; r1_addr = 32'h0000_0200;
        r0_req = 1'b1; r1_req = 1'b1;
        for (int k = 0; k < 3; k++) begin
            logic exp_owner;
            int   n;
            exp_owner = (k == 1);
            n = 0;
            while (!(r0_ack || r1_ack) && n < 12) begin
                tick();
                n++;
            end
            checks++; if ({r1_ack, r0_ack} !== (exp_owner ? 2'b10 : 2'b01)) begin errors++; $display("FAIL rr_ack_%0d: got %b expected %b", k, {r1_ack, r0_ack}, (exp_owner ? 2'b10 : 2'b01)); end
            checks++; if (owner !== exp_owner) begin errors++; $display("FAIL rr_owner_%0d: got %b expected %b", k, owner, exp_owner); end
            checks++; if ((exp_owner ? r1_rdata : r0_rdata) !== 32'hCAFE_0001) begin errors++; $display("FAIL rr_rdata_%0d: got %h expected cafe0001", k, (exp_owner ? r1_rdata : r0_rdata)); end
            if (k == 2) begin
                r0_req = 1'b0; r1_req = 1'b0;
            end
            tick();
        end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rr_idle_after: got %b expected 0", busy); end
    endtask

    task automatic test_write_split();
        int ack_cnt;
        idle_inputs();
        m_axi_if.wready = 1'b0;
        r0_we = 1'b1; r0_addr = 32'h0000_0040; r0_wdata = 32'h1122_3344; r0_wstrb = 4'hF; r0_req = 1'b1;
        tick(); // T+1, awready high
        checks++; if ({m_axi_if.awvalid, m_axi_if.wvalid} !== 2'b11) begin errors++; $display("FAIL split_t1: got %b expected 11", {m_axi_if.awvalid, m_axi_if.wvalid}); end
        for (int c = 2; c <= 4; c++) begin
            tick();
            checks++; if ({m_axi_if.awvalid, m_axi_if.wvalid, m_axi_if.bready} !== 3'b010) begin errors++; $display("FAIL split_t%0d: got %b expected 010", c, {m_axi_if.awvalid, m_axi_if.wvalid, m_axi_if.bready}); end
        end
        m_axi_if.wready = 1'b1; // T+4, three cycles after awready
        tick(); // T+5
        checks++; if ({m_axi_if.awvalid, m_axi_if.wvalid, m_axi_if.bready} !== 3'b001) begin errors++; $display("FAIL split_resp: got %b expected 001", {m_axi_if.awvalid, m_axi_if.wvalid, m_axi_if.bready}); end
        tick(); // T+6
        checks++; if ({r0_ack, r0_err, m_axi_if.bready} !== 3'b100) begin errors++; $display("FAIL split_ack: got %b expected 100", {r0_ack, r0_err, m_axi_if.bready}); end
        r0_req = 1'b0;
        ack_cnt = 0;
        for (int c = 0; c < 4; c++) begin
            tick();
            if (r0_ack || r1_ack) ack_cnt++;
        end
        checks++; if (ack_cnt !== 0) begin errors++; $display("FAIL split_extra_ack: got %0d expected 0", ack_cnt); end
    endtask

    task automatic test_read_error();
        int n;
        idle_inputs();
        m_axi_if.rresp = 2'b10; m_axi_if.rdata = 32'h1234_5678;
        r1_we = 1'b0; r1_addr = 32'h0000_0300; r1_req = 1'b1;
        n = 0;
        while (!(r0_ack || r1_ack) && n < 12) begin
            tick();
            n++;
        end
        checks++; if (n !== 3) begin errors++; $display("FAIL rderr_latency: got %0d expected 3", n); end
        checks++; if ({r1_ack, r1_err, r0_ack, owner} !== 4'b1101) begin errors++; $display("FAIL rderr_flags: got %b expected 1101", {r1_ack, r1_err, r0_ack, owner}); end
        checks++; if (r1_rdata !== 32'h1234_5678) begin errors++; $display("FAIL rderr_rdata: got %h expected 12345678", r1_rdata); end
        checks++; if (r0_rdata !== 32'h0) begin errors++; $display("FAIL rderr_other_rdata: got %h expected 0", r0_rdata); end
        r1_req = 1'b0;
        tick();
    endtask

    task automatic test_timeout();
        int n;
        int av_cnt;
        idle_inputs();
        m_axi_if.arready = 1'b0; m_axi_if.rdata = 32'hDEAD_BEEF;
        r0_we = 1'b0; r0_addr = 32'h0000_0500; r0_req = 1'b1;
        n = 0; av_cnt = 0;
        while (!r0_ack && n < 20) begin
            tick();
            n++;
            if (m_axi_if.arvalid) av_cnt++;
        end
        checks++; if (av_cnt !== 8) begin errors++; $display("FAIL tmo_arvalid_cycles: got %0d expected 8", av_cnt); end
        checks++; if (n !== 9) begin errors++; $display("FAIL tmo_ack_cycle: got %0d expected 9", n); end
        checks++; if ({r0_ack, r0_err, m_axi_if.arvalid, m_axi_if.rready} !== 4'b1100) begin errors++; $display("FAIL tmo_ack_flags: got %b expected 1100", {r0_ack, r0_err, m_axi_if.arvalid, m_axi_if.rready}); end
        checks++; if (r0_rdata !== 32'h0) begin errors++; $display("FAIL tmo_rdata: got %h expected 0", r0_rdata); end
        r0_req = 1'b0;
        tick();
        checks++; if ({busy, r0_ack} !== 2'b00) begin errors++; $display("FAIL tmo_idle: got %b expected 00", {busy, r0_ack}); end
    endtask

    task automatic test_reset_mid();
        int n;
        idle_inputs();
        m_axi_if.bvalid = 1'b0;
        r0_we = 1'b1; r0_addr = 32'h0000_0600; r0_wdata = 32'h0000_00AA; r0_wstrb = 4'h3; r0_req = 1'b1;
        n = 0;
        while (!m_axi_if.bready && n < 10) begin
            tick();
            n++;
        end
        checks++; if (m_axi_if.bready !== 1'b1) begin errors++; $display("FAIL rstmid_reach_resp: got %b expected 1", m_axi_if.bready); end
        reset = 1'b1; r0_req = 1'b0;
        tick();
        checks++; if ({busy, r0_ack, r1_ack, owner} !== 4'b0001) begin errors++; $display("FAIL rstmid_state: got %b expected 0001", {busy, r0_ack, r1_ack, owner}); end
        checks++; if ({m_axi_if.awvalid, m_axi_if.wvalid, m_axi_if.arvalid, m_axi_if.bready, m_axi_if.rready} !== 5'b00000) begin errors++; $display("FAIL rstmid_valids: got %b expected 00000", {m_axi_if.awvalid, m_axi_if.wvalid, m_axi_if.arvalid, m_axi_if.bready, m_axi_if.rready}); end
        checks++; if (m_axi_if.awaddr !== 32'h0) begin errors++; $display("FAIL rstmid_addr: got %h expected 0", m_axi_if.awaddr); end
        reset = 1'b0; m_axi_if.bvalid = 1'b1;
        tick();
        checks++; if ({busy, r0_ack} !== 2'b00) begin errors++; $display("FAIL rstmid_no_late_ack: got %b expected 00", {busy, r0_ack}); end
        m_axi_if.rdata = 32'h0BAD_F00D;
        r0_we = 1'b0; r0_addr = 32'h0000_0700; r0_req = 1'b1;
        n = 0;
        while (!r0_ack && n < 12) begin
            tick();
            n++;
        end
        checks++; if ({r0_ack, r0_err} !== 2'b10) begin errors++; $display("FAIL rstmid_next_ack: got %b expected 10", {r0_ack, r0_err}); end
        checks++; if (r0_rdata !== 32'h0BAD_F00D) begin errors++; $display("FAIL rstmid_next_rdata: got %h expected 0badf00d", r0_rdata); end
        r0_req = 1'b0;
        tick();
    endtask

    initial begin
        test_reset();
        test_write_zero_wait();
        test_round_robin();
        test_write_split();
        test_read_error();
        test_timeout();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/axil_host_arbiter.md
AXIL_HOST_ARBITER -- requirements
Module: axil_host_arbiter

Interface
REQ-001 Parameter TIMEOUT_CYC, default 1024: cycles allowed in ADDR+RESP before abort, legal range 2..65535.
REQ-002 clk  in  1  single clock; all logic on rising edge.
REQ-003 reset  in  1  synchronous, active-high reset.
REQ-004 rN_req  in  1  (N=0,1) request; held high, payload stable until rN_ack.
REQ-005 rN_we  in  1  1=write, 0=read.
REQ-006 rN_addr  in  32  byte address.
REQ-007 rN_wdata  in  32  write data.
REQ-008 rN_wstrb  in  4  write byte strobes.
REQ-009 rN_ack  out  1  one-cycle completion pulse.
REQ-010 rN_rdata  out  32  read data, valid while rN_ack.
REQ-011 rN_err  out  1  error flag, valid while rN_ack.
REQ-012 m_axi_awaddr/awvalid/awready  out/out/in  32/1/1  AXI4-Lite write address channel.
REQ-013 m_axi_wdata/wstrb/wvalid/wready  out/out/out/in  32/4/1/1  write data channel.
REQ-014 m_axi_bresp/bvalid/bready  in/in/out  2/1/1  write response channel.
REQ-015 m_axi_araddr/arvalid/arready  out/out/in  32/1/1  read address channel.
REQ-016 m_axi_rdata/rresp/rvalid/rready  in/in/in/out  32/2/1/1  read data channel.
REQ-017 owner  out  1  index of current/last granted requester.
REQ-018 busy  out  1  high in every state except IDLE.

Function
REQ-019 FSM states: IDLE, ADDR, RESP, DONE; exactly one AXI transaction outstanding at any time.
REQ-020 IDLE: if any rN_req, grant; sole requester wins; both requesting -> requester != owner wins (round-robin); owner <= grantee.
REQ-021 On grant, addr/wdata/wstrb/we latched; next cycle (ADDR) write asserts awvalid+wvalid together, read asserts arvalid.
REQ-022 ADDR write: awvalid and wvalid each drop independently on their own ready; RESP entered the cycle after both handshakes complete, including same-cycle completion of both.
REQ-023 ADDR read: arvalid drops on arready; RESP next cycle.
REQ-024 RESP: bready (write) or rready (read) high; on bvalid/rvalid handshake capture rdata (reads; 0 for writes) and err=resp[1]; go DONE.
REQ-025 DONE: rN_ack=1 for grantee only, one cycle, with rdata/err; next state IDLE; non-grantee outputs 0.
REQ-026 Minimum latency, zero-wait slave: req sampled cycle T -> valid T+1 -> ready T+1 -> RESP T+2 -> response T+2 -> ack T+3.
REQ-027 Timeout counter clears on grant, increments each cycle in ADDR/RESP; on reaching TIMEOUT_CYC: all valid/ready outputs 0, DONE with err=1, rdata=0.
REQ-028 Requester req still high in IDLE after ack is treated as a new request.
REQ-029 Requests arriving in non-IDLE states wait; never dropped, never acked twice.
REQ-030 AXI address/data outputs hold latched values from grant until next grant.

Reset
REQ-031 reset: state IDLE, owner=1 (r0 wins first tie), busy=0, all valid/ready/ack/err=0, all rdata/addr/data/strb outputs=0, timeout counter=0.
REQ-032 reset asserted mid-transaction aborts immediately: no ack issued, all outputs per REQ-031 next cycle.

Verification
REQ-033 r0 write addr 0x80006008 data 0x5A, slave zero-wait bresp=0 -> awaddr 0x80006008, wdata 0x5A, wstrb 0x1, r0_ack at T+3, r0_err=0.
REQ-034 r0 and r1 read requested same cycle after reset, both held -> r0 served first, then r1, then r0; owner toggles 0,1,0.
REQ-035 write: awready 3 cycles before wready -> awvalid drops first, wvalid held, single bready handshake, single ack.
REQ-036 r1 read, rresp=2, rdata=0x12345678 -> r1_ack with r1_err=1, r1_rdata=0x12345678.
REQ-037 TIMEOUT_CYC=8, arready never asserted -> arvalid drops after 8 cycles, ack with err=1, rdata=0, IDLE next.
REQ-038 reset pulsed while in RESP -> no ack, busy=0, all valids 0; next request completes normally.
